// File: rtl/alu_ctrl_pkg.sv
// Shared definitions for the ALU sharing controller: ALU control codes, FSM states and flag layout.
// Flags are packed {N,Z,C,V} with N in the MSB.
package alu_ctrl_pkg;

  localparam logic [2:0] ALU_PASS_B = 3'b000;
  localparam logic [2:0] ALU_ADD    = 3'b010;
  localparam logic [2:0] ALU_SUB    = 3'b011;
  localparam logic [2:0] ALU_AND    = 3'b100;
  localparam logic [2:0] ALU_OR     = 3'b101;
  localparam logic [2:0] ALU_XOR    = 3'b110;

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  function automatic logic [3:0] pack_flags(input logic n, input logic z,
                                            input logic c, input logic v);
    logic [3:0] f;
    f         = 4'b0000;
    f[FLAG_N] = n;
    f[FLAG_Z] = z;
    f[FLAG_C] = c;
    f[FLAG_V] = v;
    return f;
  endfunction

endpackage

// File: rtl/alu_share_ctrl_arb.sv
// Two-way round-robin arbiter, purely combinational: a lone request wins,
// on a tie the requester not served last wins.
module rr_arb2
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] valid,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Shares one ALU between two requesters: accept -> hold operands ALU_LAT cycles -> capture -> respond.
// One op in flight; req_ready stays low until the response handshake, rsp_valid holds until rsp_ready.
module alu_share_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 64,
  parameter int ALU_LAT = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0][2:0]       req_op,
  input  logic [1:0][WIDTH-1:0] req_a,
  input  logic [1:0][WIDTH-1:0] req_b,
  input  logic [1:0]            req_setflags,
  output logic [1:0]            rsp_valid,
  input  logic [1:0]            rsp_ready,
  output logic [WIDTH-1:0]      rsp_result,
  output logic [3:0]            rsp_flags,
  output logic [WIDTH-1:0]      alu_a,
  output logic [WIDTH-1:0]      alu_b,
  output logic [2:0]            alu_cntrl,
  input  logic [WIDTH-1:0]      alu_result,
  input  logic                  alu_negative,
  input  logic                  alu_zero,
  input  logic                  alu_carry_out,
  input  logic                  alu_overflow,
  output logic [3:0]            flags_q,
  output logic                  busy
);

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

  state_t        state;
  logic          last;
  logic          owner;
  logic          setflags;
  logic [CW-1:0] cnt;
  logic [1:0]    grant;
  logic          sel;
  logic [3:0]    alu_flags;

  rr_arb2 u_arb (
    .valid (req_valid),
    .last  (last),
    .grant (grant)
  );

  // The grant is only exposed while idle so no handshake can occur mid-op.
  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign sel       = grant[1];
  assign alu_flags = pack_flags(alu_negative, alu_zero, alu_carry_out, alu_overflow);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last       <= 1'b1;
      owner      <= 1'b0;
      setflags   <= 1'b0;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_cntrl  <= 3'b000;
      rsp_result <= '0;
      rsp_flags  <= 4'b0000;
      rsp_valid  <= 2'b00;
      flags_q    <= 4'b0000;
      busy       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|grant) begin
            alu_a     <= req_a[sel];
            alu_b     <= req_b[sel];
            alu_cntrl <= req_op[sel];
            setflags  <= req_setflags[sel];
            owner     <= sel;
            cnt       <= CW'(ALU_LAT - 1);
            busy      <= 1'b1;
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (cnt == '0) begin
            rsp_result <= alu_result;
            rsp_flags  <= alu_flags;
            if (setflags)
              flags_q <= alu_flags;
            rsp_valid <= owner ? 2'b10 : 2'b01;
            state     <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          // The non-owner's rsp_ready bit is deliberately ignored.
          if (rsp_ready[owner]) begin
            last      <= owner;
            rsp_valid <= 2'b00;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
